// File: rtl/cpu_pkg.sv
// Shared CPU types for the decode->execute boundary and the execute-stage
// skid buffer. This package is also imported by rtl/alu_core.sv and
// rtl/execute_stage.sv. Operand forwarding in execute_stage is enabled by
// defining the EXEC_FWD_EN macro.
package cpu_pkg;

  localparam int CPU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOP = 4'd5
  } alu_op_e;

  // Highest defined alu_op encoding; anything above is illegal.
  localparam logic [3:0] ALU_OP_LAST = 4'd5;

  typedef enum logic {
    SRC_A_RS1 = 1'b0
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2 = 2'd0,
    SRC_B_IMM = 2'd1
  } src_b_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       src_a_sel;
    logic [1:0] src_b_sel;
    logic       reg_write;
  } control_signals_t;

  typedef struct packed {
    logic                we;
    logic [4:0]          rd;
    logic [CPU_XLEN-1:0] data;
  } ex_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_MAIN  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the execute stage. Undefined alu_op encodings give
// a zero result and raise illegal_o; the caller treats them as NOP.
module alu_core
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
) (
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  assign illegal_o = (alu_op_i > ALU_OP_LAST);

  // Result select; NOP and undefined encodings produce zero.
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: accepts decoded ops on a valid/ready handshake, runs the
// ALU and holds results in a two-entry buffer (MAIN drives wb_*, SKID holds
// overflow) so id_ready can be registered. EXEC_FWD_EN enables forwarding
// from the MAIN entry into the rs1/rs2 operands.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the clock edge. id_ready does not depend on id_valid. Once
// wb_valid is high, wb_valid, wb_we, wb_rd and wb_data stay stable until
// wb_ready is seen.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = CPU_XLEN,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  control_signals_t       id_ctrl,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [XLEN-1:0]        id_rs1_data,
  input  logic [XLEN-1:0]        id_rs2_data,
  input  logic [XLEN-1:0]        id_imm,
  input  logic [4:0]             id_rd,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic                   wb_we,
  output logic [4:0]             wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic                   ex_illegal,
  output logic [CNT_W-1:0]       retired_cnt
);

  buf_state_t       state_q;
  ex_entry_t        main_q;
  ex_entry_t        skid_q;
  ex_entry_t        new_entry;
  logic             id_ready_q;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept, retire;
  logic [XLEN-1:0]  rs1_val, rs2_val, op_b, alu_result;
  logic             alu_illegal, src_illegal, is_nop;
  logic             unused_ok;

  assign accept = id_valid & id_ready_q;
  assign retire = (state_q != BUF_EMPTY) & wb_ready;

`ifdef EXEC_FWD_EN
  logic fwd_rs1, fwd_rs2;
  // Only MAIN can be a source: when SKID is occupied no op is accepted.
  assign fwd_rs1 = (state_q != BUF_EMPTY) & main_q.we & (id_rs1 != 5'd0) & (main_q.rd == id_rs1);
  assign fwd_rs2 = (state_q != BUF_EMPTY) & main_q.we & (id_rs2 != 5'd0) & (main_q.rd == id_rs2);
  assign rs1_val = fwd_rs1 ? main_q.data : id_rs1_data;
  assign rs2_val = fwd_rs2 ? main_q.data : id_rs2_data;
`else
  assign rs1_val = id_rs1_data;
  assign rs2_val = id_rs2_data;
`endif

  // src_a_sel is always RS1; register addresses only matter with forwarding.
  assign unused_ok = ^{id_ctrl.src_a_sel, id_rs1, id_rs2};

  assign op_b        = (id_ctrl.src_b_sel == SRC_B_IMM) ? id_imm : rs2_val;
  assign src_illegal = (id_ctrl.src_b_sel > SRC_B_IMM);

  alu_core #(.XLEN(XLEN)) u_alu (
    .alu_op_i  (id_ctrl.alu_op),
    .a_i       (rs1_val),
    .b_i       (op_b),
    .result_o  (alu_result),
    .illegal_o (alu_illegal)
  );

  // Undefined alu_op behaves as NOP; x0 is never written.
  assign is_nop         = alu_illegal | (id_ctrl.alu_op == ALU_NOP);
  assign new_entry.we   = id_ctrl.reg_write & (id_rd != 5'd0) & ~is_nop;
  assign new_entry.rd   = id_rd;
  assign new_entry.data = alu_result;

  // Buffer FSM: moves ops EMPTY->MAIN->FULL and back, keeping acceptance order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      id_ready_q <= 1'b1;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            state_q <= BUF_MAIN;
            main_q  <= new_entry;
          end
        end
        BUF_MAIN: begin
          if (accept && !retire) begin
            state_q    <= BUF_FULL;
            skid_q     <= new_entry;
            id_ready_q <= 1'b0;
          end else if (accept) begin
            main_q <= new_entry;
          end else if (retire) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
          end
        end
        BUF_FULL: begin
          if (retire) begin
            state_q    <= BUF_MAIN;
            main_q     <= skid_q;
            id_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= BUF_EMPTY;
          id_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ill_d = ill_q | (accept & (alu_illegal | src_illegal));
  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};

  // Sticky illegal flag and wrapping retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end

  assign id_ready    = id_ready_q;
  assign wb_valid    = (state_q != BUF_EMPTY);
  assign wb_we       = main_q.we;
  assign wb_rd       = main_q.rd;
  assign wb_data     = main_q.data;
  assign ex_illegal  = ill_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed scenarios plus a randomized stream
// checked against a queue-based reference model of the two-entry buffer.
module tb_execute_stage;
  import cpu_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                   id_valid;
  logic                   id_ready;
  control_signals_t       id_ctrl;
  logic [4:0]             id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]        id_rs1_data, id_rs2_data, id_imm;
  logic                   wb_valid, wb_ready, wb_we;
  logic [4:0]             wb_rd;
  logic [XLEN-1:0]        wb_data;
  logic                   ex_illegal;
  logic [CNT_W-1:0]       retired_cnt;

  execute_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_illegal(ex_illegal), .retired_cnt(retired_cnt)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Each entry is {we, rd, data}; the front is what wb_* must show.
  logic [37:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_ill = 1'b0;

  function automatic logic [37:0] model_op(input control_signals_t c,
                                           input logic [31:0] a,
                                           input logic [31:0] rs2d,
                                           input logic [31:0] imm,
                                           input logic [4:0] rd,
                                           output logic ill);
    logic [31:0] b, r;
    logic        nop;
    ill = 1'b0;
    nop = 1'b0;
    b   = rs2d;
    if (c.src_b_sel == 2'd1) b = imm;
    else if (c.src_b_sel != 2'd0) ill = 1'b1;
    case (c.alu_op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = 32'd0; nop = 1'b1; end
      default: begin r = 32'd0; nop = 1'b1; ill = 1'b1; end
    endcase
    return {(c.reg_write && rd != 5'd0 && !nop), rd, r};
  endfunction

  // One clock: advance the model with the inputs presented this cycle.
  task automatic tick();
    logic [37:0] e;
    logic        il, acc, ret;
    logic [31:0] a, b2;
    acc = id_valid && (exp_q.size() < 2);
    ret = wb_ready && (exp_q.size() > 0);
    a   = id_rs1_data;
    b2  = id_rs2_data;
`ifdef EXEC_FWD_EN
    if (exp_q.size() > 0 && exp_q[0][37] && exp_q[0][36:32] == id_rs1) a  = exp_q[0][31:0];
    if (exp_q.size() > 0 && exp_q[0][37] && exp_q[0][36:32] == id_rs2) b2 = exp_q[0][31:0];
`endif
    e = model_op(id_ctrl, a, b2, id_imm, id_rd, il);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
      exp_ill = 1'b0;
    end else begin
      if (ret) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (acc) begin
        exp_q.push_back(e);
        exp_ill = exp_ill | il;
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [3:0] op, input logic [1:0] bsel, input logic rw,
                        input logic [4:0] rs1, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rd);
    id_ctrl.alu_op    = op;
    id_ctrl.src_a_sel = 1'b0;
    id_ctrl.src_b_sel = bsel;
    id_ctrl.reg_write = rw;
    id_rs1      = rs1;
    id_rs2      = 5'd0;
    id_rs1_data = a;
    id_rs2_data = b;
    id_imm      = imm;
    id_rd       = rd;
  endtask

  task automatic drain();
    id_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
    checks++;
    if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
    checks++;
    if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    checks++;
    if (ex_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", ex_illegal); end
    checks++;
    if (retired_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", retired_cnt); end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    set_op(4'd0, 2'd0, 1'b1, 5'd0, 32'd5, 32'd7, 32'd0, 5'd3);
    id_valid = 1'b1;
    wb_ready = 1'b1;
    tick();
    if ({wb_valid, wb_we, wb_rd} !== {1'b1, 1'b1, 5'd3}) begin
      errors++; $display("FAIL add_ctrl: got v=%b we=%b rd=%0d want v=1 we=1 rd=3", wb_valid, wb_we, wb_rd);
    end
    checks++;
    if (wb_data !== 32'd12) begin errors++; $display("FAIL add_data: got %h want 0000000c", wb_data); end
    checks++;
    id_valid = 1'b0;
    tick();
    if (retired_cnt !== 4'd1) begin errors++; $display("FAIL add_cnt: got %0d want 1", retired_cnt); end
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_empty: got %b want 0", wb_valid); end
    checks++;
  endtask

  task automatic test_sub_xor();
    set_op(4'd1, 2'd1, 1'b1, 5'd0, 32'd0, 32'd99, 32'd1, 5'd5);
    id_valid = 1'b1;
    wb_ready = 1'b1;
    tick();
    if (wb_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_imm: got %h want ffffffff", wb_data); end
    checks++;
    set_op(4'd4, 2'd0, 1'b1, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 5'd6);
    tick();
    if (wb_data !== 32'h0000_FF00 || wb_rd !== 5'd6) begin
      errors++; $display("FAIL xor: got rd=%0d data=%h want rd=6 data=0000ff00", wb_rd, wb_data);
    end
    checks++;
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    id_valid = 1'b1;
    set_op(4'd0, 2'd0, 1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 5'd1);   // A = 2
    tick();
    if (id_ready !== 1'b1 || wb_data !== 32'd2) begin
      errors++; $display("FAIL b2b_a: got ready=%b data=%h want ready=1 data=2", id_ready, wb_data);
    end
    checks++;
    set_op(4'd0, 2'd0, 1'b1, 5'd0, 32'd2, 32'd2, 32'd0, 5'd2);   // B = 4
    tick();
    if (id_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got ready=%b want 0", id_ready); end
    checks++;
    set_op(4'd0, 2'd0, 1'b1, 5'd0, 32'd3, 32'd3, 32'd0, 5'd7);   // C = 6
    tick();
    tick();
    if (id_ready !== 1'b0 || wb_data !== 32'd2 || wb_rd !== 5'd1) begin
      errors++; $display("FAIL b2b_hold: got ready=%b rd=%0d data=%h want ready=0 rd=1 data=2", id_ready, wb_rd, wb_data);
    end
    checks++;
    wb_ready = 1'b1;
    tick();
    if (wb_data !== 32'd4 || id_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_b: got ready=%b data=%h want ready=1 data=4", id_ready, wb_data);
    end
    checks++;
    tick();
    if (wb_data !== 32'd6 || wb_rd !== 5'd7) begin
      errors++; $display("FAIL b2b_c: got rd=%0d data=%h want rd=7 data=6", wb_rd, wb_data);
    end
    checks++;
    id_valid = 1'b0;
    tick();
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", wb_valid); end
    checks++;
  endtask

  task automatic test_nop_illegal();
    wb_ready = 1'b1;
    id_valid = 1'b1;
    set_op(4'd0, 2'd0, 1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 5'd0);   // rd = x0
    tick();
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || ex_illegal !== 1'b0) begin
      errors++; $display("FAIL x0_write: got v=%b we=%b ill=%b want v=1 we=0 ill=0", wb_valid, wb_we, ex_illegal);
    end
    checks++;
    set_op(4'd9, 2'd0, 1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 5'd4);
    tick();
    if (wb_we !== 1'b0 || wb_data !== 32'd0 || ex_illegal !== 1'b1) begin
      errors++; $display("FAIL bad_op: got we=%b data=%h ill=%b want we=0 data=0 ill=1", wb_we, wb_data, ex_illegal);
    end
    checks++;
    id_valid = 1'b0;
    tick();
    tick();
    if (ex_illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %b want 1", ex_illegal); end
    checks++;
  endtask

  task automatic test_mid_reset();
    wb_ready = 1'b0;
    id_valid = 1'b1;
    set_op(4'd0, 2'd0, 1'b1, 5'd0, 32'd8, 32'd8, 32'd0, 5'd8);
    tick();
    tick();
    if (id_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got ready=%b want 0", id_ready); end
    checks++;
    rst = 1'b1;
    id_valid = 1'b0;
    tick();
    rst = 1'b0;
    if (wb_valid !== 1'b0 || id_ready !== 1'b1 || retired_cnt !== 4'd0 || ex_illegal !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got v=%b ready=%b cnt=%0d ill=%b want 0 1 0 0", wb_valid, id_ready, retired_cnt, ex_illegal);
    end
    checks++;
  endtask

  task automatic test_src_b_illegal();
    wb_ready = 1'b1;
    id_valid = 1'b1;
    set_op(4'd0, 2'd3, 1'b1, 5'd0, 32'd2, 32'd3, 32'd100, 5'd9);
    tick();
    if (wb_data !== 32'd5 || wb_we !== 1'b1 || ex_illegal !== 1'b1) begin
      errors++; $display("FAIL src_b_bad: got data=%h we=%b ill=%b want data=5 we=1 ill=1", wb_data, wb_we, ex_illegal);
    end
    checks++;
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_fwd();
    logic [31:0] want;
`ifdef EXEC_FWD_EN
    want = 32'd11;
`else
    want = 32'd1;
`endif
    wb_ready = 1'b0;
    id_valid = 1'b1;
    set_op(4'd0, 2'd0, 1'b1, 5'd0, 32'd10, 32'd0, 32'd0, 5'd4);
    tick();
    set_op(4'd0, 2'd1, 1'b1, 5'd4, 32'd0, 32'd0, 32'd1, 5'd5);
    tick();
    id_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    if (wb_data !== want || wb_rd !== 5'd5) begin
      errors++; $display("FAIL fwd: got rd=%0d data=%h want rd=5 data=%h", wb_rd, wb_data, want);
    end
    checks++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      id_valid = ($urandom_range(0, 9) < 7);
      wb_ready = ($urandom_range(0, 9) < 6);
      rst      = ($urandom_range(0, 149) == 0);
      id_ctrl.alu_op    = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
      id_ctrl.src_a_sel = 1'($urandom_range(0, 1));
      id_ctrl.src_b_sel = ($urandom_range(0, 19) < 19) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      id_ctrl.reg_write = ($urandom_range(0, 9) < 8);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      tick();
      if (id_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, id_ready, (exp_q.size() < 2));
      end
      checks++;
      if (wb_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, wb_valid, (exp_q.size() > 0));
      end
      checks++;
      if (exp_q.size() > 0) begin
        if ({wb_we, wb_rd, wb_data} !== exp_q[0]) begin
          errors++; $display("FAIL rnd_entry[%0d]: got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h",
                             i, wb_we, wb_rd, wb_data, exp_q[0][37], exp_q[0][36:32], exp_q[0][31:0]);
        end
        checks++;
      end
      if (ex_illegal !== exp_ill) begin
        errors++; $display("FAIL rnd_illegal[%0d]: got %b want %b", i, ex_illegal, exp_ill);
      end
      checks++;
      if (retired_cnt !== exp_cnt) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, retired_cnt, exp_cnt);
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b1;
    id_valid    = 1'b0;
    wb_ready    = 1'b0;
    id_ctrl     = '0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rs1_data = '0;
    id_rs2_data = '0;
    id_imm      = '0;
    id_rd       = '0;
    test_reset();
    test_add();
    test_sub_xor();
    test_back_to_back();
    test_nop_illegal();
    test_mid_reset();
    test_src_b_illegal();
    drain();
    test_fwd();
    test_random();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
